bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter sharing the single SoC memory bus (request/ready handshake, 32-bit address/data) between the CPU (master 0) and a second bus master such as a DMA or video fetch unit (master 1).
- Sits between the masters and the address decoder that fans out to ROM/BRAM/SRAM/LED/UART.
- Round-robin grant, held for one complete transaction; optional watchdog completes hung transactions.

Parameters:
- TIMEOUT, 1024, BUSY-state cycle count after which a transaction is force-completed (used only with BUS_ARBITER_TIMEOUT_EN); legal range 2..65535.

Ports:
- i_clock  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_m0_request  in  1  master 0 request; held until o_m0_ready
- i_m0_rw  in  1  master 0 direction (1 = write)
- i_m0_address  in  32  master 0 address
- i_m0_wdata  in  32  master 0 write data
- o_m0_rdata  out  32  master 0 read data
- o_m0_ready  out  1  master 0 transaction complete
- i_m1_request, i_m1_rw, i_m1_address, i_m1_wdata, o_m1_rdata, o_m1_ready  same as master 0, for master 1
- o_bus_request  out  1  request to decoder/slaves
- o_bus_rw  out  1  direction to slaves
- o_bus_address  out  32  address to slaves
- o_bus_wdata  out  32  write data to slaves
- i_bus_rdata  in  32  read data from slaves
- i_bus_ready  in  1  slave completion (may be combinational, e.g. ROM)
- o_owner  out  1  registered grant index
- o_busy  out  1  high in BUSY state
- o_timeout_error  out  1  sticky watchdog flag
- i_clear_error  in  1  synchronous clear of o_timeout_error

Behaviour:
- Reset (async, i_reset_n low): state=IDLE, owner=0, last=1, counter=0, error=0. Consequently all ready outputs are 0, o_bus_request=0, bus outputs=0, o_busy=0.
- IDLE:
  - No request: stay in IDLE.
  - One requester: latch it as owner, go to BUSY on the next edge.
  - Both requesting: owner = !last (round-robin). After reset master 0 wins the first tie.
  - No ready is ever asserted in IDLE.
- BUSY:
  - Bus outputs are muxed combinationally from the owner's inputs; o_bus_request = owner's request.
  - i_bus_ready && o_bus_request: owner's ready=1 in the same cycle, its rdata = i_bus_rdata. Then last=owner and go to IDLE.
  - Owner drops its request before ready (protocol violation): go to IDLE, last unchanged, no ready pulse.
- Non-owner master: ready=0, rdata=0 at all times. Bus address/wdata/rw=0 whenever o_bus_request=0.
- Latency: a request seen in IDLE at edge N is driven to the bus during cycle N+1. Best-case completion (combinational slave) is 2 cycles. Minimum 1 idle cycle between back-to-back transactions.
- A new request arriving in BUSY waits; it is never dropped.
- Master 1 requesting continuously cannot starve master 0: strict alternation whenever both request.

Optional Feature:
- Macro BUS_ARBITER_TIMEOUT_EN.
- Enabled:
  - 16-bit counter clears on entering BUSY and increments each BUSY cycle without i_bus_ready.
  - When counter == TIMEOUT-1 and no i_bus_ready: owner's ready=1 with rdata=32'h0, o_bus_request forced 0 that cycle, o_timeout_error set, go to IDLE, last=owner.
  - i_clear_error clears the flag; a set in the same cycle wins.
- Disabled: no counter, BUSY waits indefinitely, o_timeout_error tied 0, i_clear_error ignored.

Test Plan:
- Reset, then m0 reads 0x00000200 with combinational ready and i_bus_rdata=0xDEADBEEF -> o_bus_request high the cycle after the request; o_m0_ready=1 with o_m0_rdata=0xDEADBEEF in that same cycle; IDLE next cycle.
- m0 and m1 request simultaneously and repeatedly, each completing in 1 bus cycle -> grants m0, m1, m0, m1; o_owner alternates; o_m1_ready never high while o_owner=0.
- m1 writes 0x20000000 with wdata 0x41 while slave ready is delayed 5 cycles; m0 requests mid-transaction -> m1 holds bus 6 BUSY cycles; m0 granted after one IDLE cycle; m0 address appears on the bus only after that.
- i_reset_n pulsed low during BUSY -> o_bus_request and all ready outputs drop to 0 immediately (asynchronously); after release the first tie goes to m0.
- With BUS_ARBITER_TIMEOUT_EN, TIMEOUT=8, slave never ready -> o_m0_ready=1 with rdata 0 on the 8th BUSY cycle; o_timeout_error=1 until i_clear_error; without the macro the bus stays requested for 100 cycles.
- Owner drops its request after 2 BUSY cycles with no slave ready -> returns to IDLE with no ready pulse; the other master is granted next.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_if
//
// Purpose : Bundles the two master-side request/ready handshakes and the
//           shared slave-side bus of the two-master memory arbiter.
//           Signal prefixes are from the arbiter's point of view
//           (i_* flows into the arbiter, o_* flows out of it).
//
// Modports:
//   slave  - arbiter view: the arbiter serves the masters' requests
//            (and drives the slave bus).
//   master - environment view: master 0/1 request ports, decoder/slave
//            completion and read data.
//
// Signals:
//   i_m0_request / i_m1_request   master request, held until ready
//   i_m0_rw      / i_m1_rw        master direction (1 = write)
//   i_m0_address / i_m1_address   master address [31:0]
//   i_m0_wdata   / i_m1_wdata     master write data [31:0]
//   o_m0_rdata   / o_m1_rdata     read data returned to the master [31:0]
//   o_m0_ready   / o_m1_ready     master transaction complete
//   o_bus_request                 request to decoder/slaves
//   o_bus_rw                      direction to slaves
//   o_bus_address                 address to slaves [31:0]
//   o_bus_wdata                   write data to slaves [31:0]
//   i_bus_rdata                   read data from slaves [31:0]
//   i_bus_ready                   slave completion (may be combinational)
// ----------------------------------------------------------------------------
interface bus_arbiter_if;
    logic        i_m0_request;
    logic        i_m0_rw;
    logic [31:0] i_m0_address;
    logic [31:0] i_m0_wdata;
    logic [31:0] o_m0_rdata;
    logic        o_m0_ready;

    logic        i_m1_request;
    logic        i_m1_rw;
    logic [31:0] i_m1_address;
    logic [31:0] i_m1_wdata;
    logic [31:0] o_m1_rdata;
    logic        o_m1_ready;

    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ready;

    modport slave (
        input  i_m0_request, i_m0_rw, i_m0_address, i_m0_wdata,
        output o_m0_rdata, o_m0_ready,
        input  i_m1_request, i_m1_rw, i_m1_address, i_m1_wdata,
        output o_m1_rdata, o_m1_ready,
        output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
        input  i_bus_rdata, i_bus_ready
    );

    modport master (
        output i_m0_request, i_m0_rw, i_m0_address, i_m0_wdata,
        input  o_m0_rdata, o_m0_ready,
        output i_m1_request, i_m1_rw, i_m1_address, i_m1_wdata,
        input  o_m1_rdata, o_m1_ready,
        input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
        output i_bus_rdata, i_bus_ready
    );
endinterface

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//
// Purpose : Shares the single SoC memory bus between master 0 (CPU) and
//           master 1 (DMA / video fetch). Round-robin grant on a tie, grant
//           held for one complete transaction, at least one idle cycle
//           between transactions.
//
// Optional feature:
//   BUS_ARBITER_TIMEOUT_EN - when defined, a 16-bit watchdog force-completes
//   a transaction (ready=1, rdata=0) on its TIMEOUT-th BUSY cycle without
//   slave ready and sets the sticky o_timeout_error flag. When undefined,
//   BUSY waits indefinitely, o_timeout_error is 0 and i_clear_error is
//   ignored.
//
// Parameters:
//   TIMEOUT          BUSY cycles before force-completion (2..65535)
//
// Ports:
//   i_clock          system clock
//   i_reset_n        asynchronous active-low reset
//   bus_if           bus_arbiter_if.slave: both master handshakes + slave bus
//   o_owner          registered grant index (0 = master 0, 1 = master 1)
//   o_busy           high while in BUSY
//   o_timeout_error  sticky watchdog flag
//   i_clear_error    synchronous clear of o_timeout_error
// ----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    bus_arbiter_if.slave  bus_if,
    output logic          o_owner,
    output logic          o_busy,
    output logic          o_timeout_error,
    input  logic          i_clear_error
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_state;
    logic   r_owner;
    logic   r_last;
    logic   r_busy;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_counter;
    logic        r_error;
`endif

    logic w_own_req;
    logic w_pick;
    logic w_timeout_hit;
    logic w_bus_req;
    logic w_done;
    logic w_complete;

    // ------------------------------------------------------------------------
    // Grant decision and completion conditions
    // ------------------------------------------------------------------------
    always_comb begin
        w_own_req = r_owner ? bus_if.i_m1_request : bus_if.i_m0_request;

        // Tie goes to the master that did not complete last; a lone
        // requester wins outright (m1 alone -> 1, m0 alone -> 0).
        w_pick = (bus_if.i_m0_request && bus_if.i_m1_request) ? ~r_last
                                                               : bus_if.i_m1_request;

`ifdef BUS_ARBITER_TIMEOUT_EN
        // A dropped request takes precedence: that path returns to IDLE
        // silently, so the watchdog only fires while the owner still asks.
        w_timeout_hit = (r_state == ST_BUSY) && w_own_req &&
                        !bus_if.i_bus_ready && (r_counter == TIMEOUT_LAST);
`else
        w_timeout_hit = 1'b0;
`endif

        // The forced completion cycle must not look like a real access to
        // the slaves, so the bus request is withdrawn in that cycle.
        w_bus_req  = (r_state == ST_BUSY) && w_own_req && !w_timeout_hit;
        w_done     = w_bus_req && bus_if.i_bus_ready;
        w_complete = w_done || w_timeout_hit;
    end

    // ------------------------------------------------------------------------
    // Bus-side mux: only the owner's fields, and only while requesting
    // ------------------------------------------------------------------------
    always_comb begin
        bus_if.o_bus_request = w_bus_req;
        bus_if.o_bus_rw      = 1'b0;
        bus_if.o_bus_address = '0;
        bus_if.o_bus_wdata   = '0;
        if (w_bus_req) begin
            if (r_owner) begin
                bus_if.o_bus_rw      = bus_if.i_m1_rw;
                bus_if.o_bus_address = bus_if.i_m1_address;
                bus_if.o_bus_wdata   = bus_if.i_m1_wdata;
            end else begin
                bus_if.o_bus_rw      = bus_if.i_m0_rw;
                bus_if.o_bus_address = bus_if.i_m0_address;
                bus_if.o_bus_wdata   = bus_if.i_m0_wdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Master-side returns: non-owner always sees ready=0, rdata=0.
    // A watchdog completion returns zero data.
    // ------------------------------------------------------------------------
    always_comb begin
        bus_if.o_m0_ready = w_complete && !r_owner;
        bus_if.o_m1_ready = w_complete &&  r_owner;
        bus_if.o_m0_rdata = (w_done && !r_owner) ? bus_if.i_bus_rdata : '0;
        bus_if.o_m1_rdata = (w_done &&  r_owner) ? bus_if.i_bus_rdata : '0;
    end

    // ------------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_busy    <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            r_counter <= '0;
            r_error   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus_if.i_m0_request || bus_if.i_m1_request) begin
                        r_owner <= w_pick;
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        r_counter <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (!w_own_req) begin
                        // Owner abandoned the transaction: no ready, and the
                        // round-robin history is left untouched.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_complete) begin
                        r_last  <= r_owner;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
                        r_counter <= r_counter + 16'd1;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

`ifdef BUS_ARBITER_TIMEOUT_EN
            // Set has priority over a simultaneous clear.
            if (w_timeout_hit) begin
                r_error <= 1'b1;
            end else if (i_clear_error) begin
                r_error <= 1'b0;
            end
`endif
        end
    end

    assign o_owner = r_owner;
    assign o_busy  = r_busy;

`ifdef BUS_ARBITER_TIMEOUT_EN
    assign o_timeout_error = r_error;
`else
    assign o_timeout_error = 1'b0;

    // Watchdog absent: the clear input and TIMEOUT have no function.
    logic w_unused_cfg;
    assign w_unused_cfg = i_clear_error | (TIMEOUT < 2);
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int          TMO = 8;
    localparam logic [31:0] KEY = 32'h5A5A_5A5A;

    logic clk = 1'b0;
    logic rst_n;
    logic clear_err;
    logic owner;
    logic busy;
    logic terr;

    logic        fixed_mode;
    logic [31:0] fixed_val;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          master;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    bus_arbiter_if bif();

    bus_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .bus_if          (bif),
        .o_owner         (owner),
        .o_busy          (busy),
        .o_timeout_error (terr),
        .i_clear_error   (clear_err)
    );

    always #5 clk = ~clk;

    // Slave model: fixed data, or address-derived data the bench can predict.
    always_comb bif.i_bus_rdata = fixed_mode ? fixed_val : (bif.o_bus_address ^ KEY);

    // Scoreboard consumer: every completion seen must match the oldest
    // expected (master, rdata) pair.
    always @(negedge clk) begin
        exp_t        e;
        bit          act_m;
        logic [31:0] act_d;
        if (rst_n === 1'b1 && (bif.o_m0_ready === 1'b1 || bif.o_m1_ready === 1'b1)) begin
            n_checks++;
            act_m = (bif.o_m1_ready === 1'b1);
            act_d = act_m ? bif.o_m1_rdata : bif.o_m0_rdata;
            if (bif.o_m0_ready === 1'b1 && bif.o_m1_ready === 1'b1) begin
                n_fail++;
                $display("FAIL dual_ready: both ready at %0t, required one", $time);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: master %0d data %h at %0t, required none", act_m, act_d, $time);
            end else begin
                e = sb.pop_front();
                if (act_m !== e.master || act_d !== e.rdata) begin
                    n_fail++;
                    $display("FAIL sb_txn: got master %0d data %h, required master %0d data %h",
                             act_m, act_d, e.master, e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bif.i_m0_request = 1'b0; bif.i_m0_rw = 1'b0; bif.i_m0_address = '0; bif.i_m0_wdata = '0;
        bif.i_m1_request = 1'b0; bif.i_m1_rw = 1'b0; bif.i_m1_address = '0; bif.i_m1_wdata = '0;
        bif.i_bus_ready  = 1'b0;
        clear_err        = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fixed_mode = 1'b1; fixed_val = 32'hFFFF_FFFF;
        idle_inputs();
        rst_n = 1'b0;
        bif.i_m0_request = 1'b1; bif.i_m0_address = 32'h1234_0000;
        bif.i_m1_request = 1'b1; bif.i_bus_ready  = 1'b1;
        cyc(); #1;
        n_checks++; if (bif.o_bus_request !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req: %b, required 0", bif.o_bus_request); end
        n_checks++; if (bif.o_bus_address !== 32'h0) begin n_fail++; $display("FAIL rst_bus_addr: %h, required 0", bif.o_bus_address); end
        n_checks++; if (bif.o_m0_ready !== 1'b0 || bif.o_m1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: %b%b, required 00", bif.o_m0_ready, bif.o_m1_ready); end
        n_checks++; if (bif.o_m0_rdata !== 32'h0 || bif.o_m1_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: %h %h, required 0", bif.o_m0_rdata, bif.o_m1_rdata); end
        n_checks++; if (owner !== 1'b0 || busy !== 1'b0 || terr !== 1'b0) begin n_fail++; $display("FAIL rst_status: owner %b busy %b err %b, required 000", owner, busy, terr); end
        idle_inputs();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_read();
        apply_reset();
        fixed_mode = 1'b1; fixed_val = 32'hDEAD_BEEF;
        bif.i_bus_ready  = 1'b1;
        bif.i_m0_request = 1'b1; bif.i_m0_rw = 1'b0; bif.i_m0_address = 32'h0000_0200;
        sb.push_back('{master: 1'b0, rdata: 32'hDEAD_BEEF});
        #1;
        n_checks++; if (bif.o_bus_request !== 1'b0) begin n_fail++; $display("FAIL rd_idle_req: %b, required 0", bif.o_bus_request); end
        n_checks++; if (bif.o_m0_ready !== 1'b0) begin n_fail++; $display("FAIL rd_idle_ready: %b, required 0", bif.o_m0_ready); end
        cyc(); #1;
        n_checks++; if (bif.o_bus_request !== 1'b1 || bif.o_bus_address !== 32'h0000_0200) begin n_fail++; $display("FAIL rd_bus: req %b addr %h, required 1 00000200", bif.o_bus_request, bif.o_bus_address); end
        n_checks++; if (bif.o_m0_ready !== 1'b1 || bif.o_m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_ready: %b %h, required 1 deadbeef", bif.o_m0_ready, bif.o_m0_rdata); end
        n_checks++; if (bif.o_m1_ready !== 1'b0 || bif.o_m1_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_nonowner: %b %h, required 0 0", bif.o_m1_ready, bif.o_m1_rdata); end
        cyc();
        bif.i_m0_request = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || bif.o_m0_ready !== 1'b0 || bif.o_bus_address !== 32'h0) begin n_fail++; $display("FAIL rd_after: busy %b ready %b addr %h, required 0 0 0", busy, bif.o_m0_ready, bif.o_bus_address); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        fixed_mode = 1'b0;
        bif.i_bus_ready  = 1'b1;
        bif.i_m0_request = 1'b1; bif.i_m0_address = 32'h0000_0100;
        bif.i_m1_request = 1'b1; bif.i_m1_address = 32'h0000_0104;
        for (int g = 0; g < 4; g++)
            sb.push_back('{master: g[0], rdata: (g[0] ? 32'h0000_0104 : 32'h0000_0100) ^ KEY});
        for (int c = 0; c < 8; c++) begin
            if (c != 0) cyc();
            #1;
            if (c % 2 == 1) begin
                n_checks++;
                if (busy !== 1'b1 || owner !== 1'((c / 2) % 2)) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: busy %b owner %b, required 1 %0d", c, busy, owner, (c / 2) % 2);
                end
            end else begin
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle%0d: busy %b, required 0", c, busy); end
            end
            if (owner === 1'b0) begin
                n_checks++;
                if (bif.o_m1_ready !== 1'b0) begin n_fail++; $display("FAIL rr_m1_ready%0d: %b, required 0", c, bif.o_m1_ready); end
            end
            #1;
        end
        cyc();
        bif.i_m0_request = 1'b0; bif.i_m1_request = 1'b0; bif.i_bus_ready = 1'b0;
        #1;
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rr_drain: %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_delayed_write();
        apply_reset();
        fixed_mode = 1'b0;
        bif.i_bus_ready  = 1'b0;
        bif.i_m1_request = 1'b1; bif.i_m1_rw = 1'b1;
        bif.i_m1_address = 32'h2000_0000; bif.i_m1_wdata = 32'h0000_0041;
        sb.push_back('{master: 1'b1, rdata: 32'h2000_0000 ^ KEY});
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle: busy %b, required 0", busy); end
        for (int b = 1; b <= 6; b++) begin
            cyc();
            if (b == 3) begin
                bif.i_m0_request = 1'b1; bif.i_m0_rw = 1'b0; bif.i_m0_address = 32'h0000_0300;
                sb.push_back('{master: 1'b0, rdata: 32'h0000_0300 ^ KEY});
            end
            if (b == 6) bif.i_bus_ready = 1'b1;
            #1;
            n_checks++;
            if (busy !== 1'b1 || owner !== 1'b1 || bif.o_bus_rw !== 1'b1 ||
                bif.o_bus_address !== 32'h2000_0000 || bif.o_bus_wdata !== 32'h0000_0041) begin
                n_fail++;
                $display("FAIL wr_hold%0d: busy %b owner %b rw %b addr %h wdata %h, required 1 1 1 20000000 00000041",
                         b, busy, owner, bif.o_bus_rw, bif.o_bus_address, bif.o_bus_wdata);
            end
            n_checks++;
            if (bif.o_m0_ready !== 1'b0 || bif.o_m1_ready !== 1'(b == 6)) begin
                n_fail++;
                $display("FAIL wr_ready%0d: m0 %b m1 %b, required 0 %0d", b, bif.o_m0_ready, bif.o_m1_ready, b == 6);
            end
        end
        cyc();
        bif.i_m1_request = 1'b0; bif.i_m1_rw = 1'b0; bif.i_bus_ready = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || bif.o_bus_request !== 1'b0 || bif.o_bus_address !== 32'h0) begin n_fail++; $display("FAIL wr_gap: busy %b req %b addr %h, required 0 0 0", busy, bif.o_bus_request, bif.o_bus_address); end
        cyc();
        bif.i_bus_ready = 1'b1;
        #1;
        n_checks++; if (owner !== 1'b0 || bif.o_bus_address !== 32'h0000_0300 || bif.o_m0_ready !== 1'b1) begin n_fail++; $display("FAIL wr_m0_grant: owner %b addr %h ready %b, required 0 00000300 1", owner, bif.o_bus_address, bif.o_m0_ready); end
        cyc();
        bif.i_m0_request = 1'b0; bif.i_bus_ready = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_end: busy %b, required 0", busy); end
    endtask

    task automatic test_reset_during_busy();
        apply_reset();
        fixed_mode = 1'b0;
        bif.i_bus_ready  = 1'b1;
        bif.i_m0_request = 1'b1; bif.i_m0_address = 32'h0000_0500;
        sb.push_back('{master: 1'b0, rdata: 32'h0000_0500 ^ KEY});
        cyc(); #1;
        n_checks++; if (bif.o_m0_ready !== 1'b1) begin n_fail++; $display("FAIL rb_first: ready %b, required 1", bif.o_m0_ready); end
        cyc();
        bif.i_m0_request = 1'b0; bif.i_bus_ready = 1'b0;
        bif.i_m1_request = 1'b1; bif.i_m1_address = 32'h0000_0600;
        #1;
        cyc();
        bif.i_bus_ready = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b1 || owner !== 1'b1 || bif.o_bus_request !== 1'b1 || bif.o_m1_ready !== 1'b1) begin n_fail++; $display("FAIL rb_pre: busy %b owner %b req %b ready %b, required 1 1 1 1", busy, owner, bif.o_bus_request, bif.o_m1_ready); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bif.o_bus_request !== 1'b0 || bif.o_m0_ready !== 1'b0 || bif.o_m1_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rb_async: req %b ready %b%b busy %b, required 0 00 0", bif.o_bus_request, bif.o_m0_ready, bif.o_m1_ready, busy); end
        cyc();
        bif.i_m0_request = 1'b1; bif.i_m0_address = 32'h0000_0700;
        rst_n = 1'b1;
        sb.push_back('{master: 1'b0, rdata: 32'h0000_0700 ^ KEY});
        #1;
        cyc(); #1;
        n_checks++; if (owner !== 1'b0 || bif.o_m0_ready !== 1'b1) begin n_fail++; $display("FAIL rb_tie: owner %b ready %b, required 0 1", owner, bif.o_m0_ready); end
        cyc();
        bif.i_m0_request = 1'b0;
        sb.push_back('{master: 1'b1, rdata: 32'h0000_0600 ^ KEY});
        #1;
        cyc(); #1;
        n_checks++; if (owner !== 1'b1 || bif.o_m1_ready !== 1'b1) begin n_fail++; $display("FAIL rb_m1: owner %b ready %b, required 1 1", owner, bif.o_m1_ready); end
        cyc();
        bif.i_m1_request = 1'b0; bif.i_bus_ready = 1'b0;
        #1;
    endtask

    task automatic test_owner_drop();
        apply_reset();
        fixed_mode = 1'b0;
        bif.i_bus_ready  = 1'b0;
        bif.i_m0_request = 1'b1; bif.i_m0_address = 32'h0000_0800;
        bif.i_m1_request = 1'b1; bif.i_m1_address = 32'h0000_0900;
        #1;
        for (int b = 1; b <= 2; b++) begin
            cyc(); #1;
            n_checks++;
            if (busy !== 1'b1 || owner !== 1'b0 || bif.o_bus_request !== 1'b1 || bif.o_bus_address !== 32'h0000_0800) begin
                n_fail++;
                $display("FAIL od_busy%0d: busy %b owner %b req %b addr %h, required 1 0 1 00000800", b, busy, owner, bif.o_bus_request, bif.o_bus_address);
            end
        end
        cyc();
        bif.i_m0_request = 1'b0;
        #1;
        n_checks++; if (bif.o_bus_request !== 1'b0 || bif.o_bus_address !== 32'h0 || bif.o_m0_ready !== 1'b0) begin n_fail++; $display("FAIL od_drop: req %b addr %h ready %b, required 0 0 0", bif.o_bus_request, bif.o_bus_address, bif.o_m0_ready); end
        cyc();
        bif.i_bus_ready = 1'b1;
        sb.push_back('{master: 1'b1, rdata: 32'h0000_0900 ^ KEY});
        #1;
        n_checks++; if (busy !== 1'b0 || bif.o_m0_ready !== 1'b0 || bif.o_m1_ready !== 1'b0) begin n_fail++; $display("FAIL od_idle: busy %b ready %b%b, required 0 00", busy, bif.o_m0_ready, bif.o_m1_ready); end
        cyc(); #1;
        n_checks++; if (owner !== 1'b1 || bif.o_m1_ready !== 1'b1) begin n_fail++; $display("FAIL od_next: owner %b ready %b, required 1 1", owner, bif.o_m1_ready); end
        cyc();
        bif.i_m1_request = 1'b0; bif.i_bus_ready = 1'b0;
        #1;
    endtask

    task automatic test_timeout();
        apply_reset();
        fixed_mode = 1'b1; fixed_val = 32'h1234_5678;
        bif.i_bus_ready  = 1'b0;
        bif.i_m0_request = 1'b1; bif.i_m0_address = 32'h0000_0400;
`ifdef BUS_ARBITER_TIMEOUT_EN
        sb.push_back('{master: 1'b0, rdata: 32'h0});
        #1;
        for (int b = 1; b <= TMO; b++) begin
            cyc(); #1;
            if (b < TMO) begin
                n_checks++;
                if (bif.o_bus_request !== 1'b1 || bif.o_m0_ready !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: req %b ready %b, required 1 0", b, bif.o_bus_request, bif.o_m0_ready); end
            end else begin
                n_checks++;
                if (bif.o_m0_ready !== 1'b1 || bif.o_m0_rdata !== 32'h0 || bif.o_bus_request !== 1'b0) begin n_fail++; $display("FAIL to_fire: ready %b rdata %h req %b, required 1 0 0", bif.o_m0_ready, bif.o_m0_rdata, bif.o_bus_request); end
            end
        end
        cyc();
        bif.i_m0_request = 1'b0;
        #1;
        n_checks++; if (terr !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL to_flag: err %b busy %b, required 1 0", terr, busy); end
        repeat (3) cyc();
        clear_err = 1'b1;
        #1;
        n_checks++; if (terr !== 1'b1) begin n_fail++; $display("FAIL to_sticky: err %b, required 1", terr); end
        cyc();
        clear_err = 1'b0;
        #1;
        n_checks++; if (terr !== 1'b0) begin n_fail++; $display("FAIL to_clear: err %b, required 0", terr); end
`else
        #1;
        for (int b = 1; b <= 100; b++) begin
            cyc();
            clear_err = (b == 50);
            #1;
            n_checks++;
            if (bif.o_bus_request !== 1'b1 || bif.o_m0_ready !== 1'b0 || terr !== 1'b0) begin
                n_fail++;
                $display("FAIL nto_wait%0d: req %b ready %b err %b, required 1 0 0", b, bif.o_bus_request, bif.o_m0_ready, terr);
            end
        end
        cyc();
        bif.i_m0_request = 1'b0;
        #1;
        n_checks++; if (bif.o_bus_request !== 1'b0 || bif.o_m0_ready !== 1'b0) begin n_fail++; $display("FAIL nto_drop: req %b ready %b, required 0 0", bif.o_bus_request, bif.o_m0_ready); end
        cyc(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nto_idle: busy %b, required 0", busy); end
`endif
    endtask

    initial begin
        fixed_mode = 1'b0;
        fixed_val  = '0;
        rst_n      = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_delayed_write();
        test_reset_during_busy();
        test_owner_drop();
        test_timeout();
        cyc();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
